// File: rtl/mac_result_collector.sv
// Collects results from the 8x8 MAC using a latency-matched tag pipeline.
// Each result is saturated to OUT_W bits and buffered in a show-ahead FIFO with valid/ready output.
module mac_result_collector #(
    parameter int DEPTH = 4,
    parameter int OUT_W = 16,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             issue,
    input  logic             mode,
    output logic             issue_ready,
    input  logic [16:0]      mac_output,
    output logic [OUT_W-1:0] res_data,
    output logic             res_sat,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [CNT_W-1:0] drop_cnt,
    output logic             busy
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    localparam logic [CW-1:0]  FULL     = CW'(DEPTH);
    localparam logic [CW:0]    DEPTH_V  = (CW + 1)'(DEPTH);
    localparam logic [16:0]    MAX_RES  = 17'((64'd1 << OUT_W) - 64'd1);
    localparam logic [CNT_W-1:0] DROP_MAX = '1;

    typedef struct packed {
        logic             sat;
        logic [OUT_W-1:0] data;
    } entry_t;

    // Tag pipeline: s1 holds tri-path issues one cycle early, s2 marks the sample cycle.
    logic s1_q, s1_d;
    logic s2_q, s2_d;

    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q,  count_d;
    logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;

    entry_t mem_q [DEPTH];
    entry_t wr_entry;
    entry_t head;

    logic [CW:0] occupancy;
    logic        accept;
    logic        refuse;
    logic        wr_en;
    logic        pop;

    // Credits cover buffered results plus every tag that will still write.
    always_comb begin
        occupancy   = (CW + 1)'(count_q) + (CW + 1)'(s1_q) + (CW + 1)'(s2_q);
        issue_ready = (occupancy < DEPTH_V) && !(!mode && s1_q);
        accept      = issue && issue_ready;
        refuse      = issue && !issue_ready;
    end

    always_comb begin
        head      = mem_q[rd_ptr_q];
        res_valid = (count_q != '0);
        res_data  = res_valid ? head.data : '0;
        res_sat   = res_valid ? head.sat  : 1'b0;
        busy      = s1_q || s2_q || res_valid;
        drop_cnt  = drop_cnt_q;
        wr_en     = s2_q;
        pop       = res_valid && res_ready;
    end

    always_comb begin
        wr_entry.sat  = (mac_output > MAX_RES);
        wr_entry.data = wr_entry.sat ? '1 : mac_output[OUT_W-1:0];
    end

    // NOTE: every signal gets a default at the top of the block so no path leaves it unassigned (no latches).
    always_comb begin
        s1_d       = accept && mode;
        s2_d       = s1_q || (accept && !mode);
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        drop_cnt_d = drop_cnt_q;

        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        if (wr_en && !pop) begin
            count_d = count_q + CW'(1);
        end else if (!wr_en && pop) begin
            count_d = count_q - CW'(1);
        end

        if (refuse && (drop_cnt_q != DROP_MAX)) begin
            drop_cnt_d = drop_cnt_q + CNT_W'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_q       <= 1'b0;
            s2_q       <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            drop_cnt_q <= '0;
        end else begin
            s1_q       <= s1_d;
            s2_q       <= s2_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    // NOTE: storage is not reset; count gates res_valid and the output data, so stale entries are never visible.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= wr_entry;
        end
    end

    // Credit accounting must make a write into a full FIFO impossible.
    a_no_overflow: assert property (@(posedge clk) disable iff (reset) !(wr_en && (count_q == FULL)));

    // A mode-0 issue must never land in s2 while an older tri-path tag is moving there.
    a_no_collision: assert property (@(posedge clk) disable iff (reset) !(s1_q && accept && !mode));

endmodule

// File: tb/tb_mac_result_collector.sv
// Scoreboard bench for mac_result_collector: a bench-side MAC model drives mac_output only on the
// cycle the accepted issue's result is due, and expected results are queued at accept time.
module tb_mac_result_collector;

    localparam int DEPTH = 4;
    localparam int OUT_W = 16;
    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             issue = 1'b0;
    logic             mode = 1'b0;
    logic             res_ready = 1'b0;
    logic [16:0]      mac_output = '0;
    logic             issue_ready;
    logic [OUT_W-1:0] res_data;
    logic             res_sat;
    logic             res_valid;
    logic [CNT_W-1:0] drop_cnt;
    logic             busy;

    mac_result_collector #(.DEPTH(DEPTH), .OUT_W(OUT_W), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .reset       (reset),
        .issue       (issue),
        .mode        (mode),
        .issue_ready (issue_ready),
        .mac_output  (mac_output),
        .res_data    (res_data),
        .res_sat     (res_sat),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .drop_cnt    (drop_cnt),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference state
    bit          m_s1 = 1'b0;
    bit          m_s2 = 1'b0;
    int          m_count = 0;
    int          m_drop = 0;
    logic [16:0] sb [$];
    bit          cur_v = 1'b0;
    bit          nxt_v = 1'b0;
    logic [16:0] cur_val = '0;
    logic [16:0] nxt_val = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [16:0] expect_of(input logic [16:0] v);
        if (v > 17'h0FFFF) return {1'b1, 16'hFFFF};
        return {1'b0, v[15:0]};
    endfunction

    // One clock cycle; entered and left at posedge+1.
    task automatic cycle(input bit iss, input bit md, input bit rr, input logic [16:0] v, input string tag);
        bit rdy, acc, pop, wr;
        logic [16:0] head;
        issue      = iss;
        mode       = md;
        res_ready  = rr;
        mac_output = cur_v ? cur_val : 17'($urandom);
        @(negedge clk);
        rdy = ((m_count + int'(m_s1) + int'(m_s2)) < DEPTH) && !(!md && m_s1);
        check($sformatf("%s.ready", tag), 32'(issue_ready), 32'(rdy));
        check($sformatf("%s.valid", tag), 32'(res_valid), 32'(m_count != 0));
        check($sformatf("%s.busy", tag), 32'(busy), 32'(m_s1 || m_s2 || (m_count != 0)));
        check($sformatf("%s.drop", tag), 32'(drop_cnt), 32'(m_drop));
        if (m_count != 0 && sb.size() != 0) begin
            head = sb[0];
            check($sformatf("%s.data", tag), 32'(res_data), 32'(head[15:0]));
            check($sformatf("%s.sat", tag), 32'(res_sat), 32'(head[16]));
        end
        acc = iss && rdy;
        pop = (m_count != 0) && rr;
        wr  = m_s2;
        if (pop) void'(sb.pop_front());
        if (acc) sb.push_back(expect_of(v));
        m_count = m_count + int'(wr) - int'(pop);
        m_s2    = m_s1 || (acc && !md);
        m_s1    = acc && md;
        if (iss && !rdy && m_drop < 255) m_drop++;
        cur_v   = nxt_v;
        cur_val = nxt_val;
        nxt_v   = 1'b0;
        if (acc) begin
            if (!md) begin
                cur_v   = 1'b1;
                cur_val = v;
            end else begin
                nxt_v   = 1'b1;
                nxt_val = v;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n, input bit rr, input string tag);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, rr, 17'h0, tag);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, ".valid"}, 32'(res_valid), 32'd0);
        check({tag, ".data"}, 32'(res_data), 32'd0);
        check({tag, ".sat"}, 32'(res_sat), 32'd0);
        check({tag, ".busy"}, 32'(busy), 32'd0);
        check({tag, ".ready"}, 32'(issue_ready), 32'd1);
        check({tag, ".drop"}, 32'(drop_cnt), 32'd0);
    endtask

    initial begin
        #2;
        check_reset_outputs("rst0");
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Sum path: sampled one cycle after issue, visible the cycle after that.
        cycle(1'b1, 1'b0, 1'b0, 17'h00123, "t1");
        idle(3, 1'b0, "t1");
        idle(2, 1'b1, "t1d");

        // Tri path with a value that saturates.
        cycle(1'b1, 1'b1, 1'b1, 17'h10005, "t2");
        idle(4, 1'b1, "t2d");

        // Mode-0 right behind mode-1 is refused; one cycle later it is accepted.
        cycle(1'b1, 1'b1, 1'b1, 17'h00456, "t3a");
        cycle(1'b1, 1'b0, 1'b1, 17'h00789, "t3b");
        cycle(1'b1, 1'b0, 1'b1, 17'h00abc, "t3c");
        idle(4, 1'b1, "t3d");
        check("t3.drop_total", 32'(drop_cnt), 32'd1);

        // Back-pressure: six back-to-back issues with the consumer stalled.
        for (int i = 0; i < 6; i++) cycle(1'b1, 1'b0, 1'b0, 17'(17'h00a00 + i), "t4");
        idle(2, 1'b0, "t4s");
        check("t4.drop_total", 32'(drop_cnt), 32'd3);
        idle(6, 1'b1, "t4d");

        // Hold three entries, then stream with concurrent writes and pops across pointer wrap.
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b0, 17'(17'h01100 + i), "t5f");
        idle(1, 1'b0, "t5f");
        for (int i = 0; i < 10; i++) cycle(1'b1, 1'(i % 3 == 2), 1'b1, 17'(17'h0ff00 + 17'(i) * 17'h00081), "t5s");
        idle(6, 1'b1, "t5d");

        // Reset with two entries buffered and two tags in flight.
        cycle(1'b1, 1'b0, 1'b0, 17'h02001, "t6f");
        cycle(1'b1, 1'b0, 1'b0, 17'h02002, "t6f");
        idle(1, 1'b0, "t6f");
        cycle(1'b1, 1'b1, 1'b0, 17'h02003, "t6i");
        cycle(1'b1, 1'b1, 1'b0, 17'h02004, "t6i");
        check("t6.busy_pre", 32'(busy), 32'd1);
        issue = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        check_reset_outputs("t6rst");
        m_s1 = 1'b0;
        m_s2 = 1'b0;
        m_count = 0;
        m_drop = 0;
        sb.delete();
        cur_v = 1'b0;
        nxt_v = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        idle(6, 1'b1, "t6post");

        // Random traffic.
        for (int i = 0; i < 60; i++) begin
            cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0),
                  17'($urandom_range(0, 17'h1ffff)), "rnd");
        end
        idle(8, 1'b1, "rnd_d");
        check("final.sb_empty", 32'(sb.size()), 32'd0);
        check("final.busy", 32'(busy), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mac_result_collector.md
Name: mac_result_collector

Overview:
- Sits directly downstream of the 8x8 MAC unit and consumes its 17-bit mac_output.
- The MAC has no valid signalling, so this block tracks each issued operation with a tag pipeline matched to the MAC's output latency for the selected mode. It samples mac_output on the correct cycle.
- Each sample is saturated to OUT_W bits and buffered in a small FIFO with a valid/ready output.
- Issue back-pressure is credit-based, so no result is ever lost.

Parameters:
- DEPTH, 4, result FIFO entries; power of 2, 2..16.
- OUT_W, 16, output result width; results above 2^OUT_W-1 saturate.
- CNT_W, 8, width of the saturating drop counter.

Ports:
- clk  in  1  system clock; all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- issue  in  1  operands for one MAC operation are presented to the MAC this cycle.
- mode  in  1  mode driven to the MAC this cycle: 0 = sum path, 1 = tri path.
- issue_ready  out  1  an issue this cycle will be accepted.
- mac_output  in  17  MAC result bus.
- res_data  out  OUT_W  head-of-FIFO result.
- res_sat  out  1  head result was saturated.
- res_valid  out  1  FIFO non-empty.
- res_ready  in  1  consumer accepts head this cycle.
- drop_cnt  out  CNT_W  issues refused while issue_ready=0; saturating.
- busy  out  1  any tag in flight or FIFO non-empty.

Behaviour:
- Reset, asynchronous and immediate: tag pipeline, FIFO pointers and count, and drop_cnt cleared.
  - Outputs during reset: res_valid=0, res_data=0, res_sat=0, busy=0, issue_ready=1.
  - Reset mid-operation discards in-flight tags and buffered results; nothing is emitted after release.
- Latency contract with the MAC, for an issue accepted in cycle t:
  - mode=0: result valid on mac_output in cycle t+1.
  - mode=1: result valid on mac_output in cycle t+2.
- Tag pipeline: two stages, s1 and s2, each holding a valid bit.
  - Accepted mode=1 issue enters s1 and moves to s2 next cycle.
  - Accepted mode=0 issue enters s2 directly.
  - s2 valid in a cycle means mac_output is sampled and written to the FIFO at the end of that cycle.
- inflight = s1 + s2, range 0..2.
- issue_ready = ((count + inflight) < DEPTH) AND NOT (mode=0 AND s1 valid).
  - The second term prevents a mode-0 tag colliding in s2 with an older mode-1 tag.
  - Computed from registered state plus the current mode. No lookahead on a same-cycle pop.
- Accepted issue: issue AND issue_ready.
- Refused issue: issue AND NOT issue_ready. Increments drop_cnt, which saturates at 2^CNT_W-1. No tag is created.
- Saturation on FIFO write:
  - If mac_output >= 2^OUT_W: stored data = all ones, sat = 1.
  - Otherwise: stored data = mac_output[OUT_W-1:0], sat = 0.
- FIFO:
  - Synchronous write from s2; pop on res_valid AND res_ready.
  - Simultaneous write and pop allowed at any count; count unchanged, pointers both advance.
  - Pointers wrap modulo DEPTH.
  - Credit accounting guarantees no write when full. Overflow is an assertion failure, not handled.
  - Pop when empty has no effect.
- res_data and res_sat come from FIFO head (show-ahead) and are stable while res_valid=1 and res_ready=0.
- busy = s1 OR s2 OR (count != 0).

Test Plan:
- Single mode=0 issue at cycle 0 with mac_output=17'h00123 in cycle 1 -> res_valid rises in cycle 2; res_data=16'h0123, res_sat=0.
- Single mode=1 issue at cycle 0 with mac_output=17'h1_0005 in cycle 2 -> res_valid in cycle 3; res_data=16'hFFFF, res_sat=1.
- mode=1 issue at cycle 0, then mode=0 issue at cycle 1 -> issue_ready=0 in cycle 1, drop_cnt=1; a mode=0 issue at cycle 2 is accepted.
- res_ready=0, 6 back-to-back mode=0 issues with distinct values -> first 4 accepted in order, issue_ready falls once count+inflight reaches 4, drop_cnt=2; then res_ready=1 -> 4 results drain in issue order.
- FIFO holding 3 entries with a write and a pop in the same cycle -> count stays 3, data order preserved across pointer wrap.
- Reset asserted mid-stream with 2 tags in flight and 2 entries buffered -> immediately res_valid=0, busy=0, drop_cnt=0; no result appears after release.
